// File: rtl/muldiv_seq_pkg.sv
// rtl/muldiv_seq_pkg.sv - shared codes for the MUL AB / DIV AB sequencer
package muldiv_seq_pkg;

  typedef enum logic [1:0] {
    PSW_NONE     = 2'b00,
    CY_SET       = 2'b01,
    CY_OV_SET    = 2'b10,
    CY_OV_AC_SET = 2'b11
  } psw_e;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one shift-add (MUL) or restoring trial-subtract (DIV) iteration
module muldiv_step
  import muldiv_seq_pkg::*;
(
  input  logic       op,
  input  logic [7:0] hi,
  input  logic [7:0] lo,
  input  logic [7:0] operand,
  output logic [7:0] hi_next,
  output logic [7:0] lo_next
);

  logic [8:0] sum;
  logic [8:0] trial;
  logic       fits;

  always_comb begin
    sum     = 9'd0;
    trial   = 9'd0;
    fits    = 1'b0;
    hi_next = hi;
    lo_next = lo;
    if (op == OP_MUL) begin
      // lo holds the remaining multiplier bits; the product's low half shifts in from the top
      sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : 9'd0);
      hi_next = sum[8:1];
      lo_next = {sum[0], lo[7:1]};
    end else begin
      // 9-bit partial remainder; when it fits the difference is below the divisor, so 8 bits hold it
      trial   = {hi, lo[7]};
      fits    = (trial >= {1'b0, operand});
      hi_next = fits ? (trial[7:0] - operand) : trial[7:0];
      lo_next = {lo[6:0], fits};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - multi-cycle sequencer for 8051 MUL AB / DIV AB with PSW flag update
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       op,
  input  logic [7:0] acc_in,
  input  logic [7:0] b_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] acc_out,
  output logic [7:0] b_out,
  output logic       carry_out,
  output logic       overflow_out,
  output logic [1:0] psw_set
);

  localparam logic [3:0] STEP = 4'(BITS_PER_CYCLE);

  state_e     state, state_next;
  logic       op_r;
  logic [7:0] operand_r;
  logic [7:0] hi_r, lo_r;
  logic [3:0] count;
  logic [7:0] hi_end, lo_end;
  logic       div_zero;
  logic       last_step;

  assign div_zero  = (op == OP_DIV) && (b_in == 8'h00);
  assign last_step = ((count + STEP) == 4'd8);

  // Unrolled iteration chain: BITS_PER_CYCLE cells evaluated per clock
  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
    logic [7:0] hi_i, lo_i, hi_o, lo_o;
    if (i == 0) begin : g_first
      assign hi_i = hi_r;
      assign lo_i = lo_r;
    end else begin : g_next
      assign hi_i = g_step[i-1].hi_o;
      assign lo_i = g_step[i-1].lo_o;
    end
    muldiv_step u_step (
      .op      (op_r),
      .hi      (hi_i),
      .lo      (lo_i),
      .operand (operand_r),
      .hi_next (hi_o),
      .lo_next (lo_o)
    );
  end

  assign hi_end = g_step[BITS_PER_CYCLE-1].hi_o;
  assign lo_end = g_step[BITS_PER_CYCLE-1].lo_o;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = div_zero ? DONE : RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_r         <= OP_MUL;
      operand_r    <= 8'h00;
      hi_r         <= 8'h00;
      lo_r         <= 8'h00;
      count        <= 4'd0;
      acc_out      <= 8'h00;
      b_out        <= 8'h00;
      overflow_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_r  <= op;
            count <= 4'd0;
            hi_r  <= 8'h00;
            // MUL shifts the multiplier (B) out of lo; DIV shifts the dividend (A) out of lo
            if (op == OP_MUL) begin
              operand_r <= acc_in;
              lo_r      <= b_in;
            end else begin
              operand_r <= b_in;
              lo_r      <= acc_in;
            end
            if (div_zero) begin
              acc_out      <= acc_in;
              b_out        <= 8'h00;
              overflow_out <= 1'b1;
            end
          end
        end
        RUN: begin
          hi_r  <= hi_end;
          lo_r  <= lo_end;
          count <= count + STEP;
          if (last_step) begin
            acc_out      <= lo_end;
            b_out        <= hi_end;
            overflow_out <= (op_r == OP_MUL) && (hi_end != 8'h00);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign psw_set   = (state == DONE) ? CY_OV_SET : PSW_NONE;
  assign carry_out = 1'b0;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - self-checking bench for muldiv_seq at 1, 4 and 8 iterations per cycle
module tb_muldiv_seq;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       op = 1'b0;
  logic [7:0] acc_in = 8'h00;
  logic [7:0] b_in = 8'h00;
  logic [2:0] start_v = 3'b000;

  logic [2:0]       busy_v, done_v, cy_v, ov_v;
  logic [2:0][7:0]  acc_v, b_v;
  logic [2:0][1:0]  ps_v;

  int checks = 0;
  int errors = 0;
  int bpc_of [3] = '{1, 4, 8};

  always #5 clock = ~clock;

  muldiv_seq #(.BITS_PER_CYCLE(1)) dut1 (
    .clock(clock), .reset(reset), .start(start_v[0]), .op(op), .acc_in(acc_in), .b_in(b_in),
    .busy(busy_v[0]), .done(done_v[0]), .acc_out(acc_v[0]), .b_out(b_v[0]),
    .carry_out(cy_v[0]), .overflow_out(ov_v[0]), .psw_set(ps_v[0]));

  muldiv_seq #(.BITS_PER_CYCLE(4)) dut4 (
    .clock(clock), .reset(reset), .start(start_v[1]), .op(op), .acc_in(acc_in), .b_in(b_in),
    .busy(busy_v[1]), .done(done_v[1]), .acc_out(acc_v[1]), .b_out(b_v[1]),
    .carry_out(cy_v[1]), .overflow_out(ov_v[1]), .psw_set(ps_v[1]));

  muldiv_seq #(.BITS_PER_CYCLE(8)) dut8 (
    .clock(clock), .reset(reset), .start(start_v[2]), .op(op), .acc_in(acc_in), .b_in(b_in),
    .busy(busy_v[2]), .done(done_v[2]), .acc_out(acc_v[2]), .b_out(b_v[2]),
    .carry_out(cy_v[2]), .overflow_out(ov_v[2]), .psw_set(ps_v[2]));

  typedef struct {
    logic       op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] e_acc;
    logic [7:0] e_b;
    logic       e_ov;
    int         e_lat;
  } vec_t;

  vec_t vt [9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference: the architectural result of MUL AB / DIV AB, plus the cycle count from start to done
  task automatic model(input logic o, input logic [7:0] a, input logic [7:0] b, input int bpc,
                       output logic [7:0] ea, output logic [7:0] eb, output logic eov,
                       output int elat);
    int p;
    if (o == 1'b0) begin
      p   = int'(a) * int'(b);
      ea  = 8'(p % 256);
      eb  = 8'(p / 256);
      eov = (p > 255);
      elat = 8 / bpc;
    end else if (b == 8'h00) begin
      ea = a; eb = 8'h00; eov = 1'b1; elat = 0;
    end else begin
      ea = 8'(int'(a) / int'(b));
      eb = 8'(int'(a) % int'(b));
      eov = 1'b0;
      elat = 8 / bpc;
    end
  endtask

  task automatic do_op(input int d, input logic o, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] ea, input logic [7:0] eb, input logic eov,
                       input int elat, input string tag);
    int lat;
    @(negedge clock);
    op = o; acc_in = a; b_in = b; start_v[d] = 1'b1;
    @(posedge clock); #1;
    start_v[d] = 1'b0;
    op = 1'($urandom); acc_in = 8'($urandom); b_in = 8'($urandom);
    chk({tag, "_busy"}, int'(busy_v[d]), 1);
    lat = 0;
    while (!done_v[d] && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_acc"}, int'(acc_v[d]), int'(ea));
    chk({tag, "_b"}, int'(b_v[d]), int'(eb));
    chk({tag, "_ov"}, int'(ov_v[d]), int'(eov));
    chk({tag, "_cy"}, int'(cy_v[d]), 0);
    chk({tag, "_psw"}, int'(ps_v[d]), 2);
    @(posedge clock); #1;
    chk({tag, "_done_clr"}, int'(done_v[d]), 0);
    chk({tag, "_busy_clr"}, int'(busy_v[d]), 0);
    chk({tag, "_psw_clr"}, int'(ps_v[d]), 0);
    chk({tag, "_acc_hold"}, int'(acc_v[d]), int'(ea));
  endtask

  task automatic rand_op(input int d, input string tag);
    logic       o;
    logic [7:0] a, b, ea, eb;
    logic       eov;
    int         elat;
    o = 1'($urandom);
    a = 8'($urandom);
    b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
    model(o, a, b, bpc_of[d], ea, eb, eov, elat);
    do_op(d, o, a, b, ea, eb, eov, elat, tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;

    vt[0] = '{1'b0, 8'h50, 8'hA0, 8'h00, 8'h32, 1'b1, 8};
    vt[1] = '{1'b0, 8'h0C, 8'h0A, 8'h78, 8'h00, 1'b0, 8};
    vt[2] = '{1'b1, 8'hFB, 8'h12, 8'h0D, 8'h11, 1'b0, 8};
    vt[3] = '{1'b1, 8'h55, 8'h00, 8'h55, 8'h00, 1'b1, 0};
    vt[4] = '{1'b0, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b1, 8};
    vt[5] = '{1'b1, 8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 8};
    vt[6] = '{1'b0, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b0, 8};
    vt[7] = '{1'b1, 8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0, 8};
    vt[8] = '{1'b1, 8'h07, 8'hFF, 8'h00, 8'h07, 1'b0, 8};

    #3;
    chk("rst_busy", int'(busy_v[0]), 0);
    chk("rst_done", int'(done_v[0]), 0);
    chk("rst_acc", int'(acc_v[0]), 0);
    chk("rst_b", int'(b_v[0]), 0);
    chk("rst_cy", int'(cy_v[0]), 0);
    chk("rst_ov", int'(ov_v[0]), 0);
    chk("rst_psw", int'(ps_v[0]), 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 9; i++)
      do_op(0, vt[i].op, vt[i].a, vt[i].b, vt[i].e_acc, vt[i].e_b, vt[i].e_ov, vt[i].e_lat,
            $sformatf("vec%0d", i));

    do_op(1, 1'b0, 8'h50, 8'hA0, 8'h00, 8'h32, 1'b1, 2, "bpc4_mul");
    do_op(2, 1'b0, 8'h50, 8'hA0, 8'h00, 8'h32, 1'b1, 1, "bpc8_mul");
    do_op(1, 1'b1, 8'h55, 8'h00, 8'h55, 8'h00, 1'b1, 0, "bpc4_div0");

    // Starts during RUN and during DONE must be dropped, not queued
    @(negedge clock);
    op = 1'b0; acc_in = 8'hFF; b_in = 8'hFF; start_v[0] = 1'b1;
    @(posedge clock); #1;
    start_v[0] = 1'b0;
    lat = 0;
    repeat (2) begin @(posedge clock); #1; lat++; end
    @(negedge clock);
    op = 1'b1; acc_in = 8'h20; b_in = 8'h00; start_v[0] = 1'b1;
    @(posedge clock); #1;
    lat++;
    start_v[0] = 1'b0;
    chk("ign_run_done", int'(done_v[0]), 0);
    while (!done_v[0] && lat < 20) begin @(posedge clock); #1; lat++; end
    chk("ign_lat", lat, 8);
    chk("ign_acc", int'(acc_v[0]), 8'h01);
    chk("ign_b", int'(b_v[0]), 8'hFE);
    chk("ign_ov", int'(ov_v[0]), 1);
    op = 1'b0; acc_in = 8'h02; b_in = 8'h03; start_v[0] = 1'b1;
    @(posedge clock); #1;
    start_v[0] = 1'b0;
    chk("ign_done_busy", int'(busy_v[0]), 0);
    chk("ign_done_done", int'(done_v[0]), 0);
    @(posedge clock); #1;
    chk("ign_idle_busy", int'(busy_v[0]), 0);
    chk("ign_idle_acc", int'(acc_v[0]), 8'h01);

    // Asynchronous reset mid-RUN aborts without a done pulse
    @(negedge clock);
    op = 1'b0; acc_in = 8'h50; b_in = 8'hA0; start_v[0] = 1'b1;
    @(posedge clock); #1;
    start_v[0] = 1'b0;
    repeat (5) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    chk("arst_busy", int'(busy_v[0]), 0);
    chk("arst_done", int'(done_v[0]), 0);
    chk("arst_acc", int'(acc_v[0]), 0);
    chk("arst_b", int'(b_v[0]), 0);
    chk("arst_ov", int'(ov_v[0]), 0);
    chk("arst_psw", int'(ps_v[0]), 0);
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clock); #1;
      if (done_v[0] || busy_v[0]) seen++;
    end
    chk("arst_no_done", seen, 0);
    do_op(0, 1'b1, 8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 8, "arst_div");

    for (int i = 0; i < 30; i++) rand_op(0, $sformatf("rnd1_%0d", i));
    for (int i = 0; i < 10; i++) rand_op(1, $sformatf("rnd4_%0d", i));
    for (int i = 0; i < 10; i++) rand_op(2, $sformatf("rnd8_%0d", i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Multi-cycle sequencer for the 8051 MUL AB and DIV AB instructions. It takes A and B from the core, iterates a shift-add or restoring-subtract datapath, and returns the result pair. On completion it drives the PSW flag-update interface (carry_out, overflow_out, psw_set) for exactly one cycle. It sits between the instruction decoder/ALU and the psw block, and stalls the core through busy.

Parameters:
BITS_PER_CYCLE, 1, iterations performed per clock. Legal values are 1, 2, 4 and 8. RUN lasts 8/BITS_PER_CYCLE cycles.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  request pulse; sampled only in IDLE
op  in  1  0 = MUL AB, 1 = DIV AB
acc_in  in  8  accumulator operand
b_in  in  8  B register operand
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse; results and flags valid
acc_out  out  8  MUL: product[7:0]; DIV: quotient
b_out  out  8  MUL: product[15:8]; DIV: remainder
carry_out  out  1  new CY value; always 0
overflow_out  out  1  new OV value
psw_set  out  2  PSW update code to the psw block

Behaviour:
- Reset: state=IDLE, busy=0, done=0, acc_out=0x00, b_out=0x00, carry_out=0, overflow_out=0, psw_set=PSW_NONE, iteration counter=0.
- Reset is asynchronous and may arrive mid-operation. It aborts immediately to the reset values; no done pulse and no flag update follow.
- State machine: IDLE, RUN, DONE.
- IDLE, start=1 sampled at edge N:
  - Latch op, acc_in and b_in; clear the partial-result registers.
  - If op=DIV and b_in=0x00, go to DONE (div-by-zero path). Otherwise go to RUN with counter=0.
- IDLE, start=0: hold all outputs.
- RUN:
  - Each edge applies BITS_PER_CYCLE iterations.
  - counter increments by BITS_PER_CYCLE. Go to DONE at the edge where counter reaches 8.
  - MUL datapath: 16-bit shift-add, multiplicand A, multiplier B, LSB first.
  - DIV datapath: restoring division with 9-bit partial remainder; dividend A, divisor B, MSB first.
- DONE: lasts exactly one cycle; done=1, psw_set=CY_OV_SET, then go to IDLE.
  - acc_out/b_out are updated on the edge entering DONE and held until the next accepted start.
  - MUL: overflow_out = (product[15:8] != 0).
  - DIV normal: overflow_out=0.
  - DIV by zero: overflow_out=1, acc_out=original A, b_out=0x00 (the original B).
  - carry_out=0 in all cases.
- Latency with BITS_PER_CYCLE=1: start at edge N gives done high between edges N+8 and N+9; busy is high from edge N to edge N+9. Div-by-zero: done high between edges N and N+1.
- start while busy=1, including in the DONE cycle, is ignored and never queued. A new request is accepted at the first IDLE cycle.
- psw_set=PSW_NONE and done=0 in every non-DONE cycle, so the psw block never sees a stale update.
- Operand inputs are don't-care after the edge where start is accepted.

Decomposition:
- define_opcodes.v carries:
  - psw_set codes: PSW_NONE=2'b00, CY_SET=2'b01, CY_OV_SET=2'b10, CY_OV_AC_SET=2'b11.
  - op codes: OP_MUL=1'b0, OP_DIV=1'b1.
  - FSM state encodings: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
- Sub-module muldiv_step: combinational single-iteration cell (add/shift or trial-subtract/shift, selected by op). It is instantiated BITS_PER_CYCLE times in a generate chain.
- The top level holds the FSM, counter and registers.

Test Plan:
- MUL, A=0x50, B=0xA0 -> done at edge N+8; acc_out=0x00, b_out=0x32, carry_out=0, overflow_out=1, psw_set=CY_OV_SET for 1 cycle.
- MUL, A=0x0C, B=0x0A -> acc_out=0x78, b_out=0x00, overflow_out=0. DIV, A=0xFB, B=0x12 -> acc_out=0x0D, b_out=0x11, overflow_out=0.
- DIV, A=0x55, B=0x00 -> done after 1 cycle; acc_out=0x55, b_out=0x00, overflow_out=1, carry_out=0.
- MUL 0xFF×0xFF started, second start pulsed at RUN cycle 3 and in DONE -> both ignored; single done with acc_out=0x01, b_out=0xFE, overflow_out=1; busy low the cycle after DONE.
- reset asserted at RUN cycle 5 -> all outputs at reset values immediately, no done. Then DIV 0x64/0x07 -> acc_out=0x0E, b_out=0x02.
- BITS_PER_CYCLE=4 build, MUL 0x50×0xA0 -> done high between edges N+2 and N+3 with the same results as the first scenario. Repeat with BITS_PER_CYCLE=8 -> done between edges N+1 and N+2.
